// File: rtl/ldpc_rd_addr_seq_if.sv
// Scheduler-to-sequencer bus for the LDPC message-RAM read-address sequencer.
// The master is the layer scheduler; the slave is ldpc_rd_addr_seq.
interface ldpc_rd_addr_seq_if #(
    parameter int A_WID = 8,
    parameter int N_OFF = 3,
    parameter int IDX_W = 2
);
    logic                   start;
    logic [A_WID-1:0]       base_addr;
    logic [N_OFF*A_WID-1:0] addr_offset;
    logic [N_OFF-1:0]       off_mask;
    logic                   stall;
    logic                   busy;
    logic                   rd_valid;
    logic [A_WID-1:0]       rd_addr;
    logic [IDX_W-1:0]       rd_idx;
    logic                   done;

    modport master (
        output start, base_addr, addr_offset, off_mask, stall,
        input  busy, rd_valid, rd_addr, rd_idx, done
    );

    modport slave (
        input  start, base_addr, addr_offset, off_mask, stall,
        output busy, rd_valid, rd_addr, rd_idx, done
    );
endinterface

// File: rtl/ldpc_rd_addr_seq.sv
// Read-address sequencer: one start latches a base and N_OFF circulant offsets,
// then emits (base + offset) mod Z per slot with mask, stall and done reporting.
module ldpc_rd_addr_seq #(
    parameter int A_WID = 8,
    parameter int N_OFF = 3,
    parameter int Z     = 127,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    ldpc_rd_addr_seq_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [A_WID:0] Z_W = (A_WID+1)'(Z);

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx;
    logic [A_WID-1:0]       base_q;
    logic [N_OFF*A_WID-1:0] off_q;
    logic [N_OFF-1:0]       mask_q;

    logic                   accept, advance, last;
    logic [A_WID-1:0]       off_sel, addr_cur;
    logic                   mask_sel;
    logic [A_WID:0]         sum;

    logic                   rd_valid_q, done_q;
    logic [A_WID-1:0]       rd_addr_q;
    logic [IDX_W-1:0]       rd_idx_q;

    assign accept  = (state == IDLE) && bus.start;
    assign advance = (state == RUN) && !bus.stall;
    assign last    = (idx == IDX_W'(N_OFF - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (bus.start)            state_nx = RUN;
            RUN:     if (!bus.stall && last)   state_nx = IDLE;
            default:                           state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
    end

    // Slot 0 lives in the MSB slice of the offsets and the MSB bit of the mask.
    always_comb begin
        off_sel  = '0;
        mask_sel = 1'b0;
        for (int i = 0; i < N_OFF; i++) begin
            if (idx == IDX_W'(i)) begin
                off_sel  = off_q[(N_OFF-i)*A_WID-1 -: A_WID];
                mask_sel = mask_q[N_OFF-1-i];
            end
        end
    end

    // One conditional subtraction: in-range operands wrap exactly once.
    always_comb begin
        sum      = {1'b0, base_q} + {1'b0, off_sel};
        addr_cur = (sum >= Z_W) ? A_WID'(sum - Z_W) : sum[A_WID-1:0];
    end

    // NOTE: operand registers are only meaningful after an accepted start, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q <= bus.base_addr;
            off_q  <= bus.addr_offset;
            mask_q <= bus.off_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        idx <= '0;
        else if (accept)  idx <= '0;
        else if (advance) idx <= last ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_idx_q   <= '0;
            done_q     <= 1'b0;
        end else if (advance) begin
            rd_valid_q <= mask_sel;
            rd_addr_q  <= mask_sel ? addr_cur : '0;
            rd_idx_q   <= idx;
            done_q     <= last;
        end else if (state == RUN) begin
            // Stalled: report nothing but keep the slot index on the bus.
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_idx_q   <= '0;
            done_q     <= 1'b0;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.rd_idx   = rd_idx_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ldpc_rd_addr_seq.sv
// Scoreboard bench for ldpc_rd_addr_seq: expected per-cycle outputs are queued
// when a sequence is launched and compared on each falling edge.
module tb_ldpc_rd_addr_seq;
    localparam int A_WID = 8;
    localparam int N_OFF = 3;
    localparam int Z     = 127;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic             busy;
        logic             valid;
        logic [A_WID-1:0] addr;
        logic [IDX_W-1:0] idx;
        logic             done;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    exp_t  sb[$];
    exp_t  e;
    string cur_tag = "init";
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    ldpc_rd_addr_seq_if #(.A_WID(A_WID), .N_OFF(N_OFF), .IDX_W(IDX_W)) bus ();

    ldpc_rd_addr_seq #(.A_WID(A_WID), .N_OFF(N_OFF), .Z(Z), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    task automatic push(input logic b, input logic v, input int a, input int i, input logic d);
        exp_t x;
        x.busy  = b;
        x.valid = v;
        x.addr  = A_WID'(a);
        x.idx   = IDX_W'(i);
        x.done  = d;
        sb.push_back(x);
    endtask

    task automatic push_idle();
        push(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({cur_tag, ".busy"},  32'(bus.busy),     32'(e.busy));
            check({cur_tag, ".valid"}, 32'(bus.rd_valid), 32'(e.valid));
            check({cur_tag, ".addr"},  32'(bus.rd_addr),  32'(e.addr));
            check({cur_tag, ".idx"},   32'(bus.rd_idx),   32'(e.idx));
            check({cur_tag, ".done"},  32'(bus.done),     32'(e.done));
        end
    end

    // Drives start for one edge (E0) and returns 1 time unit after it.
    task automatic start_seq(input int base, input int o0, input int o1, input int o2,
                             input logic [N_OFF-1:0] mask);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = A_WID'(base);
        bus.addr_offset = {A_WID'(o0), A_WID'(o1), A_WID'(o2)};
        bus.off_mask    = mask;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({cur_tag, ".timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.base_addr   = '0;
        bus.addr_offset = '0;
        bus.off_mask    = '0;
        bus.stall       = 1'b0;

        cur_tag = "reset";
        @(posedge clk);
        @(posedge clk);
        #1;
        push_idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_drain();

        // Plain sequence, all slots enabled.
        cur_tag = "basic";
        start_seq(10, 5, 20, 100, 3'b111);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 1, 30, 1, 0);
        push(0, 1, 110, 2, 1);
        push_idle();
        wait_drain();

        // Modulo wrap, including sum exactly equal to Z; stall in IDLE is ignored.
        cur_tag = "wrap";
        bus.stall = 1'b1;
        start_seq(120, 6, 7, 126, 3'b111);
        bus.stall = 1'b0;
        push(1, 0, 0, 0, 0);
        push(1, 1, 126, 0, 0);
        push(1, 1, 0, 1, 0);
        push(0, 1, 119, 2, 1);
        push_idle();
        wait_drain();

        // Skipped middle slot still reports its index.
        cur_tag = "mask101";
        start_seq(10, 5, 20, 100, 3'b101);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 0, 0, 1, 0);
        push(0, 1, 110, 2, 1);
        push_idle();
        wait_drain();

        // Skipped last slot still produces done.
        cur_tag = "mask110";
        start_seq(10, 5, 20, 100, 3'b110);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 1, 30, 1, 0);
        push(0, 0, 0, 2, 1);
        push_idle();
        wait_drain();

        // Two stall cycles after slot 0 delay the rest and hold rd_idx.
        cur_tag = "stall";
        start_seq(10, 5, 20, 100, 3'b111);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0);
        push(1, 1, 30, 1, 0);
        push(0, 1, 110, 2, 1);
        push_idle();
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        wait_drain();

        // Start in RUN is ignored and must not disturb the latched operands.
        cur_tag = "start_in_run";
        start_seq(10, 5, 20, 100, 3'b111);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 1, 30, 1, 0);
        push(0, 1, 110, 2, 1);
        push_idle();
        push_idle();
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = 8'd50;
        bus.addr_offset = {8'd1, 8'd2, 8'd3};
        bus.off_mask    = 3'b010;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // Reset during slot 1: outputs clear, done never appears.
        cur_tag = "reset_mid";
        start_seq(10, 5, 20, 100, 3'b111);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 1, 30, 1, 0);
        push_idle();
        push_idle();
        push_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_drain();

        // Back-to-back: start in the done cycle is accepted.
        cur_tag = "b2b";
        start_seq(10, 5, 20, 100, 3'b111);
        push(1, 0, 0, 0, 0);
        push(1, 1, 15, 0, 0);
        push(1, 1, 30, 1, 0);
        push(0, 1, 110, 2, 1);
        push(1, 0, 0, 0, 0);
        push(1, 1, 126, 0, 0);
        push(1, 1, 0, 1, 0);
        push(0, 1, 119, 2, 1);
        push_idle();
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start       = 1'b1;
        bus.base_addr   = 8'd120;
        bus.addr_offset = {8'd6, 8'd7, 8'd126};
        bus.off_mask    = 3'b111;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
